// File: rtl/ras_pkg.sv
// Shared types for the return-address-stack branch scheduler.
package ras_pkg;

  localparam int RAS_MAXBRANCHES   = 16;
  localparam int RAS_BRANCHES_ADDR = 4;
  localparam int RAS_WIDTH         = 32;

  typedef logic [RAS_BRANCHES_ADDR-1:0] tag_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_RECOVER
  } sched_state_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_BRANCH,
    CMD_CLOSE_VALID,
    CMD_CLOSE_INVALID
  } ras_cmd_e;

  // Saturating increment for 32-bit event counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ras_tag_ring.sv
// Branch tag ring: per-tag live/resolved/mispred scoreboard, head/tail
// pointers and the count of open tags. Optional RAS_SCHED_STATS_EN exposes
// a dropped-resolution strobe for the statistics counters.
module ras_tag_ring
  import ras_pkg::*;
#(
  parameter int MAXBRANCHES   = 16,
  parameter int BRANCHES_ADDR = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alloc,
  input  logic                     resolve,
  input  logic [BRANCHES_ADDR-1:0] resolve_tag,
  input  logic                     resolve_mispred,
  input  logic                     retire,
  input  logic                     clear_all,
  output logic [BRANCHES_ADDR-1:0] tail,
  output logic [BRANCHES_ADDR:0]   outstanding,
  output logic                     full,
  output logic                     head_live,
  output logic                     head_resolved,
  output logic                     head_mispred
`ifdef RAS_SCHED_STATS_EN
  ,
  output logic                     res_drop
`endif
);

  logic [MAXBRANCHES-1:0]   live;
  logic [MAXBRANCHES-1:0]   resolved;
  logic [MAXBRANCHES-1:0]   mispred;
  logic [BRANCHES_ADDR-1:0] head;
  logic                     res_ok;

  // A resolution only counts for a tag that is open and not yet resolved.
  assign res_ok        = resolve && live[resolve_tag] && !resolved[resolve_tag];
  assign head_live     = live[head];
  assign head_resolved = resolved[head];
  assign head_mispred  = mispred[head];
  assign full          = (outstanding == (BRANCHES_ADDR+1)'(MAXBRANCHES));

`ifdef RAS_SCHED_STATS_EN
  assign res_drop = resolve && !res_ok;
`endif

  // Scoreboard, pointers and occupancy; a flush wipes everything and snaps
  // head to tail so the next allocation continues the tag sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live        <= '0;
      resolved    <= '0;
      mispred     <= '0;
      head        <= '0;
      tail        <= '0;
      outstanding <= '0;
    end else if (clear_all) begin
      live        <= '0;
      resolved    <= '0;
      mispred     <= '0;
      head        <= tail;
      outstanding <= '0;
    end else begin
      if (res_ok) begin
        resolved[resolve_tag] <= 1'b1;
        mispred[resolve_tag]  <= resolve_mispred;
      end
      if (retire) begin
        live[head] <= 1'b0;
        head       <= head + 1'b1;
      end
      if (alloc) begin
        live[tail]     <= 1'b1;
        resolved[tail] <= 1'b0;
        mispred[tail]  <= 1'b0;
        tail           <= tail + 1'b1;
      end
      case ({alloc, retire})
        2'b10:   outstanding <= outstanding + (BRANCHES_ADDR+1)'(1);
        2'b01:   outstanding <= outstanding - (BRANCHES_ADDR+1)'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: rtl/ras_branch_sched.sv
// Branch scheduler in front of the return address stack: allocates tags in
// order, takes resolutions out of order, retires oldest-first and registers
// every ras command. Optional RAS_SCHED_STATS_EN adds saturating counters.
module ras_branch_sched
  import ras_pkg::*;
#(
  parameter int MAXBRANCHES   = 16,
  parameter int BRANCHES_ADDR = 4,
  parameter int WIDTH         = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fe_push,
  input  logic                     fe_pop,
  input  logic [WIDTH-1:0]         fe_din,
  output logic                     fe_ready,
  input  logic                     br_open_valid,
  output logic                     br_open_ready,
  output logic [BRANCHES_ADDR-1:0] br_open_tag,
  input  logic                     res_valid,
  input  logic [BRANCHES_ADDR-1:0] res_tag,
  input  logic                     res_mispredict,
  output logic                     ras_push,
  output logic                     ras_pop,
  output logic                     ras_branch,
  output logic                     ras_close_valid,
  output logic                     ras_close_invalid,
  output logic [WIDTH-1:0]         ras_din,
  output logic [BRANCHES_ADDR:0]   outstanding,
  output logic                     flush_done
`ifdef RAS_SCHED_STATS_EN
  ,
  output logic [31:0]              stat_commits,
  output logic [31:0]              stat_flushes,
  output logic [31:0]              stat_stale_res,
  output logic [31:0]              stat_open_stalls
`endif
);

  sched_state_e state, state_nxt;
  ras_cmd_e     cmd_nxt;
  logic         do_kill, do_commit, do_open;
  logic         fe_take_push, fe_take_pop;
  logic         ring_full, head_live, head_resolved, head_mispred;
`ifdef RAS_SCHED_STATS_EN
  logic         res_drop;
`endif

  ras_tag_ring #(
    .MAXBRANCHES  (MAXBRANCHES),
    .BRANCHES_ADDR(BRANCHES_ADDR)
  ) u_ring (
    .clk            (clk),
    .rst_n          (rst_n),
    .alloc          (do_open),
    .resolve        (res_valid),
    .resolve_tag    (res_tag),
    .resolve_mispred(res_mispredict),
    .retire         (do_commit),
    .clear_all      (do_kill),
    .tail           (br_open_tag),
    .outstanding    (outstanding),
    .full           (ring_full),
    .head_live      (head_live),
    .head_resolved  (head_resolved),
    .head_mispred   (head_mispred)
`ifdef RAS_SCHED_STATS_EN
    ,
    .res_drop       (res_drop)
`endif
  );

  assign fe_take_push = fe_push && fe_ready;
  assign fe_take_pop  = fe_pop  && fe_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Commit arbitration (flush > retire > open), handshakes and next state;
  // the front end is held off from the flush decision through recovery.
  always_comb begin
    state_nxt     = state;
    do_kill       = 1'b0;
    do_commit     = 1'b0;
    do_open       = 1'b0;
    br_open_ready = 1'b0;
    fe_ready      = 1'b0;
    cmd_nxt       = CMD_NONE;
    case (state)
      ST_RUN: begin
        do_kill       = head_live && head_resolved && head_mispred;
        do_commit     = head_live && head_resolved && !head_mispred;
        br_open_ready = !do_kill && !do_commit && !ring_full;
        fe_ready      = !do_kill;
        do_open       = br_open_valid && br_open_ready;
        if (do_kill) begin
          cmd_nxt   = CMD_CLOSE_INVALID;
          state_nxt = ST_FLUSH;
        end else if (do_commit) begin
          cmd_nxt = CMD_CLOSE_VALID;
        end else if (do_open) begin
          cmd_nxt = CMD_BRANCH;
        end
      end
      ST_FLUSH:   state_nxt = ST_RECOVER;
      ST_RECOVER: state_nxt = ST_RUN;
      default:    state_nxt = ST_RUN;
    endcase
  end

  // Registered ras command/data outputs and the post-flush pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_push          <= 1'b0;
      ras_pop           <= 1'b0;
      ras_din           <= '0;
      ras_branch        <= 1'b0;
      ras_close_valid   <= 1'b0;
      ras_close_invalid <= 1'b0;
      flush_done        <= 1'b0;
    end else begin
      ras_push          <= fe_take_push;
      ras_pop           <= fe_take_pop;
      ras_din           <= fe_take_push ? fe_din : '0;
      ras_branch        <= (cmd_nxt == CMD_BRANCH);
      ras_close_valid   <= (cmd_nxt == CMD_CLOSE_VALID);
      ras_close_invalid <= (cmd_nxt == CMD_CLOSE_INVALID);
      flush_done        <= (state == ST_FLUSH);
    end
  end

  a_one_cmd: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({ras_branch, ras_close_valid, ras_close_invalid}));

`ifdef RAS_SCHED_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_commits     <= '0;
      stat_flushes     <= '0;
      stat_stale_res   <= '0;
      stat_open_stalls <= '0;
    end else begin
      if (do_commit) stat_commits <= sat_inc32(stat_commits);
      if (do_kill)   stat_flushes <= sat_inc32(stat_flushes);
      if (res_drop)  stat_stale_res <= sat_inc32(stat_stale_res);
      if (br_open_valid && !br_open_ready) stat_open_stalls <= sat_inc32(stat_open_stalls);
    end
  end
`endif

endmodule
